// File: rtl/seven_seg_decoder.sv
// Sign code + 3 BCD digits -> signed 8-bit value via reverse double-dabble, one shift per clock.
// Latency: result valid 10 clocks after the accepting edge, fixed for good and bad requests.
// Backpressure: one request in flight; in_ready low until the result is taken with out_ready.
module seven_seg_decoder #(
    parameter logic [3:0] NEG_CODE = 4'd15,
    parameter logic [3:0] POS_CODE = 4'd14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] sign,
    input  logic [3:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] number,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] bcd_q;
    logic [9:0]  bin_q;
    logic        neg_q;
    logic        bad_q;
    logic [3:0]  cnt_q;

    logic [11:0] bcd_sh;
    logic [11:0] bcd_nxt;
    logic [9:0]  bin_nxt;
    logic        last_shift;
    logic        load_bad;
    logic [7:0]  number_nxt;
    logic        err_nxt;

    assign last_shift = (state == CONV) && (cnt_q == 4'd9);
    assign load_bad   = ((sign != NEG_CODE) && (sign != POS_CODE)) ||
                        (hun > 4'd9) || (ten > 4'd9) || (one > 4'd9);

    // Shift right across the BCD/binary boundary, then pull each digit back by 3 if it reached 8+.
    always_comb begin
        bcd_sh  = {1'b0, bcd_q[11:1]};
        bin_nxt = {bcd_q[0], bin_q[9:1]};
        bcd_nxt = bcd_sh;
        for (int d = 0; d < 3; d++) begin
            if (bcd_sh[d*4 +: 4] >= 4'd8) begin
                bcd_nxt[d*4 +: 4] = bcd_sh[d*4 +: 4] - 4'd3;
            end
        end
    end

    // Range check uses the magnitude produced by the final shift, so the result lands with DONE.
    always_comb begin
        number_nxt = 8'h00;
        err_nxt    = 1'b1;
        if (!bad_q) begin
            if (!neg_q && (bin_nxt <= 10'd127)) begin
                number_nxt = bin_nxt[7:0];
                err_nxt    = 1'b0;
            end else if (neg_q && (bin_nxt <= 10'd128)) begin
                number_nxt = 8'h00 - bin_nxt[7:0];
                err_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CONV;
            CONV:    if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            neg_q  <= 1'b0;
            bad_q  <= 1'b0;
            cnt_q  <= '0;
            number <= 8'h00;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q <= {hun, ten, one};
                        bin_q <= '0;
                        neg_q <= (sign == NEG_CODE);
                        bad_q <= load_bad;
                        cnt_q <= '0;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_nxt;
                    bin_q <= bin_nxt;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_shift) begin
                        number <= number_nxt;
                        err    <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Randomised and directed requests; a monitor compares DONE results against an arithmetic model.
module tb_seven_seg_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] sign = 4'd0;
    logic [3:0] hun = 4'd0;
    logic [3:0] ten = 4'd0;
    logic [3:0] one = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] number;
    logic       err;

    typedef struct {
        logic [7:0] num;
        logic       err;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    logic prev_vld = 1'b0;
    logic [8:0] held = '0;

    seven_seg_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .hun(hun), .ten(ten), .one(one),
        .out_valid(out_valid), .out_ready(out_ready), .number(number), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = ($urandom % 4) != 0;
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: decimal value of the digits, then sign and range rules.
    function automatic exp_t model(input logic [3:0] s, h, t, o);
        exp_t r;
        int   mag;
        bit   bad;
        bit   neg;
        mag   = int'(h) * 100 + int'(t) * 10 + int'(o);
        bad   = (s != 4'd15 && s != 4'd14) || h > 9 || t > 9 || o > 9;
        neg   = (s == 4'd15);
        r.acc = 0;
        if (bad || (!neg && mag > 127) || (neg && mag > 128)) begin
            r.num = 8'h00;
            r.err = 1'b1;
        end else begin
            r.num = neg ? 8'(-mag) : 8'(mag);
            r.err = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else if (out_valid) begin
            if (!prev_vld) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output number=%0h err=%0d", number, err);
                end else begin
                    chk("latency", cyc - q[0].acc, 10);
                end
            end else begin
                chk("held_result", int'({err, number}), int'(held));
            end
            held = {err, number};
            if (out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("number", int'(number), int'(e.num));
                chk("err", int'(err), int'(e.err));
            end
            prev_vld = !out_ready;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic send(input logic [3:0] s, h, t, o);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        sign = s; hun = h; ten = t; one = o; in_valid = 1'b1;
        @(posedge clk); #1;
        e     = model(s, h, t, o);
        e.acc = cyc;
        q.push_back(e);
        in_valid = 1'b0;
        chk("in_ready_after_accept", int'(in_ready), 0);
    endtask

    // Wait for the result to be taken while throwing junk at the idle-gated inputs.
    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 300) begin
            @(posedge clk); #1; n++;
            if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom);
                sign = 4'($urandom); hun = 4'($urandom); ten = 4'($urandom); one = 4'($urandom);
            end
        end
        in_valid = 1'b0;
        if (q.size() != 0 || !in_ready) chk("drain_timeout", 0, 1);
    endtask

    task automatic send_val(input int v);
        int a;
        a = (v < 0) ? -v : v;
        send((v < 0) ? 4'd15 : 4'd14, 4'(a / 100), 4'((a / 10) % 10), 4'(a % 10));
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[256];
        int n;
        #3;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_number", int'(number), 0);
        chk("rst_err", int'(err), 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        send(4'd14, 4'd1, 4'd2, 4'd7);  drain();
        send(4'd15, 4'd1, 4'd2, 4'd8);  drain();
        send(4'd15, 4'd0, 4'd0, 4'd0);  drain();
        send(4'd14, 4'd1, 4'd2, 4'd8);  drain();
        send(4'd15, 4'd9, 4'd9, 4'd9);  drain();
        send(4'd3,  4'd0, 4'd0, 4'd5);  drain();
        send(4'd14, 4'd0, 4'd0, 4'hA);  drain();

        // Result must stay put while the consumer stalls, then the block frees up.
        rdy_mode = 1;
        send(4'd15, 4'd0, 4'd9, 4'd9);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #3; n++;
        end
        chk("hold_reached_done", int'(out_valid), 1);
        repeat (5) begin
            @(posedge clk); #3;
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        rdy_mode = 2;
        @(posedge clk); #3;
        chk("ready_raised_still_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        chk("after_take_out_valid", int'(out_valid), 0);
        chk("after_take_in_ready", int'(in_ready), 1);
        chk("after_take_queue", q.size(), 0);
        rdy_mode = 0;

        // Asynchronous reset in the middle of a conversion.
        send(4'd14, 4'd0, 4'd9, 4'd9);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_number", int'(number), 0);
        chk("midrst_err", int'(err), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'd14, 4'd0, 4'd4, 4'd2);  drain();

        for (int i = 0; i < 256; i++) vals[i] = i - 128;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 256; i++) send_val(vals[i]);

        for (int i = 0; i < 40; i++) begin
            send(($urandom % 2) ? 4'($urandom) : 4'(14 + ($urandom % 2)),
                 4'($urandom_range(11, 0)), 4'($urandom_range(11, 0)), 4'($urandom_range(11, 0)));
            drain();
        end

        repeat (5) @(posedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
